// File: rtl/stack_cpu_pkg.sv
// Shared opcode, state and fault encodings for the stack_cpu core.
package cpu_pkg;

   typedef enum logic [7:0] {
      OP_NOP  = 8'h00,
      OP_PUSH = 8'h01,
      OP_OUT  = 8'h02,
      OP_ADD  = 8'h03,
      OP_SUB  = 8'h04,
      OP_MUL  = 8'h05,
      OP_ST   = 8'h06,
      OP_LD   = 8'h07,
      OP_AND  = 8'h08,
      OP_OR   = 8'h09,
      OP_DUP  = 8'h0A,
      OP_DROP = 8'h0B,
      OP_JMP  = 8'h0C,
      OP_JZ   = 8'h0D,
      OP_HALT = 8'hFF
   } opcode_e;

   typedef enum logic [1:0] {
      ST_EXEC = 2'd0,
      ST_MEM  = 2'd1,
      ST_HALT = 2'd2
   } state_e;

   localparam logic [1:0] FLT_NONE = 2'b00;
   localparam logic [1:0] FLT_OVF  = 2'b01;
   localparam logic [1:0] FLT_UNF  = 2'b10;
   localparam logic [1:0] FLT_ILL  = 2'b11;

endpackage

// File: rtl/stack_cpu_alu.sv
// Combinational binary-op unit for stack_cpu; multiply exists only when
// STACK_CPU_MUL_EN is defined.
module stack_cpu_alu
   import cpu_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic [7:0]    op_i,
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   output logic [DW-1:0] y_o
);

   always_comb begin
      y_o = '0;
      case (op_i)
         OP_ADD: y_o = a_i + b_i;
         OP_SUB: y_o = a_i - b_i;
`ifdef STACK_CPU_MUL_EN
         OP_MUL: y_o = a_i * b_i;
`endif
         OP_AND: y_o = a_i & b_i;
         OP_OR:  y_o = a_i | b_i;
         default: y_o = '0;
      endcase
   end

endmodule

// File: rtl/stack_cpu.sv
// Two-cycle-per-instruction stack machine core. Define STACK_CPU_MUL_EN to
// make opcode 05 a multiply; otherwise it decodes as illegal.
module stack_cpu
   import cpu_pkg::*;
#(
   parameter int DW    = 8,
   parameter int DEPTH = 16,
   parameter int PCW   = 10
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [15:0]              insn,
   output logic [PCW-1:0]           pc,
   output logic [7:0]               mem_addr,
   input  logic [DW-1:0]            rd_data,
   output logic                     mem_wr,
   output logic [DW-1:0]            wr_data,
   output logic [DW-1:0]            out_data,
   output logic                     out_wr,
   output logic [$clog2(DEPTH):0]   sp,
   output logic                     halted,
   output logic [1:0]               fault
);

   localparam int AW = $clog2(DEPTH);
   localparam int SW = AW + 1;

   state_e          state_q, state_d;
   logic [PCW-1:0]  pc_q, pc_d, pc_nxt_q, pc_nxt_d;
   logic [SW-1:0]   sp_q, sp_d;
   logic [DW-1:0]   out_data_q, out_data_d, wr_data_q, wr_data_d;
   logic            out_wr_q, out_wr_d, mem_wr_q, mem_wr_d;
   logic [1:0]      fault_q, fault_d;
   logic [DW-1:0]   stk_q [DEPTH];

   logic [7:0]      opc, operand;
   logic [AW-1:0]   top_idx, nxt_idx, wr_idx;
   logic [DW-1:0]   top, nxt, alu_y, push_val;
   logic [1:0]      need, pops;
   logic            push, push_en, legal, halt_op, jump, out_en, st_en;
   logic            underflow, overflow;

   assign opc     = insn[15:8];
   assign operand = insn[7:0];
   assign top_idx = sp_q[AW-1:0] - AW'(1);
   assign nxt_idx = sp_q[AW-1:0] - AW'(2);
   assign top     = stk_q[top_idx];
   assign nxt     = stk_q[nxt_idx];
   assign wr_idx  = sp_q[AW-1:0] - AW'(pops);

   stack_cpu_alu #(.DW(DW)) u_alu (
      .op_i (opc),
      .a_i  (nxt),
      .b_i  (top),
      .y_o  (alu_y)
   );

   // Decode: operands required, entries popped, whether one is pushed.
   always_comb begin
      need     = 2'd0;
      pops     = 2'd0;
      push     = 1'b0;
      push_val = alu_y;
      legal    = 1'b1;
      halt_op  = 1'b0;
      jump     = 1'b0;
      out_en   = 1'b0;
      st_en    = 1'b0;
      case (opc)
         OP_NOP: ;
         OP_PUSH: begin push = 1'b1; push_val = DW'(operand); end
         OP_OUT:  begin need = 2'd1; out_en = 1'b1; end
         OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            need = 2'd2; pops = 2'd2; push = 1'b1;
         end
`ifdef STACK_CPU_MUL_EN
         OP_MUL:  begin need = 2'd2; pops = 2'd2; push = 1'b1; end
`endif
         OP_ST:   begin need = 2'd1; pops = 2'd1; st_en = 1'b1; end
         OP_LD:   begin push = 1'b1; push_val = rd_data; end
         OP_DUP:  begin need = 2'd1; push = 1'b1; push_val = top; end
         OP_DROP: begin need = 2'd1; pops = 2'd1; end
         OP_JMP:  jump = 1'b1;
         OP_JZ:   begin need = 2'd1; pops = 2'd1; jump = (top == '0); end
         OP_HALT: halt_op = 1'b1;
         default: legal = 1'b0;
      endcase
   end

   assign underflow = (sp_q < SW'(need));
   assign overflow  = push && (pops == 2'd0) && (sp_q == SW'(DEPTH));

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pc_nxt_d   = pc_nxt_q;
      sp_d       = sp_q;
      out_data_d = out_data_q;
      wr_data_d  = wr_data_q;
      out_wr_d   = 1'b0;
      mem_wr_d   = 1'b0;
      fault_d    = fault_q;
      push_en    = 1'b0;
      case (state_q)
         ST_EXEC: begin
            if (!legal) begin
               fault_d = FLT_ILL;
               state_d = ST_HALT;
            end else if (underflow) begin
               fault_d = FLT_UNF;
               state_d = ST_HALT;
            end else if (overflow) begin
               fault_d = FLT_OVF;
               state_d = ST_HALT;
            end else if (halt_op) begin
               state_d = ST_HALT;
            end else begin
               state_d  = ST_MEM;
               sp_d     = sp_q - SW'(pops) + SW'(push);
               push_en  = push;
               pc_nxt_d = jump ? PCW'(operand) : pc_q + PCW'(1);
               out_wr_d = out_en;
               mem_wr_d = st_en;
               if (out_en) out_data_d = top;
               if (st_en)  wr_data_d  = top;
            end
         end
         ST_MEM: begin
            pc_d    = pc_nxt_q;
            state_d = ST_EXEC;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_EXEC;
         pc_q       <= '0;
         pc_nxt_q   <= '0;
         sp_q       <= '0;
         out_data_q <= '0;
         wr_data_q  <= '0;
         out_wr_q   <= 1'b0;
         mem_wr_q   <= 1'b0;
         fault_q    <= FLT_NONE;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pc_nxt_q   <= pc_nxt_d;
         sp_q       <= sp_d;
         out_data_q <= out_data_d;
         wr_data_q  <= wr_data_d;
         out_wr_q   <= out_wr_d;
         mem_wr_q   <= mem_wr_d;
         fault_q    <= fault_d;
      end
   end

   // Entries are not reset; sp guarantees nothing is read before written.
   always_ff @(posedge clk) begin
      if (push_en) stk_q[wr_idx] <= push_val;
   end

   assign pc       = pc_q;
   assign sp       = sp_q;
   assign mem_addr = operand;
   assign mem_wr   = mem_wr_q;
   assign wr_data  = wr_data_q;
   assign out_data = out_data_q;
   assign out_wr   = out_wr_q;
   assign halted   = (state_q == ST_HALT);
   assign fault    = fault_q;

endmodule

// File: tb/tb_stack_cpu.sv
// Self-checking bench for stack_cpu: directed programs plus random programs
// compared against an instruction-level interpreter.
module tb_stack_cpu;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int PCW   = 10;
   localparam int unsigned PCMOD = 1 << PCW;
`ifdef STACK_CPU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [15:0]            insn;
   logic [PCW-1:0]         pc;
   logic [7:0]             mem_addr;
   logic [DW-1:0]          rd_data;
   logic                   mem_wr;
   logic [DW-1:0]          wr_data;
   logic [DW-1:0]          out_data;
   logic                   out_wr;
   logic [$clog2(DEPTH):0] sp;
   logic                   halted;
   logic [1:0]             fault;

   logic [15:0]   prog [1024];
   logic [DW-1:0] dmem [256];

   int n_checks = 0;
   int n_errors = 0;

   // Reference interpreter state
   logic [DW-1:0] stk [$];
   logic [DW-1:0] m_dmem [256];
   int unsigned   m_pc, pc_before;
   logic [DW-1:0] m_out, m_wr;
   logic [1:0]    m_fault;
   logic          m_halt, e_outwr, e_memwr;
   logic [7:0]    e_addr;

   stack_cpu #(.DW(DW), .DEPTH(DEPTH), .PCW(PCW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .insn     (insn),
      .pc       (pc),
      .mem_addr (mem_addr),
      .rd_data  (rd_data),
      .mem_wr   (mem_wr),
      .wr_data  (wr_data),
      .out_data (out_data),
      .out_wr   (out_wr),
      .sp       (sp),
      .halted   (halted),
      .fault    (fault)
   );

   always #5 clk = ~clk;

   assign insn    = prog[pc];
   assign rd_data = dmem[mem_addr];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, expv, $time);
      end
   endtask

   task automatic mfault(input logic [1:0] code);
      m_fault = code;
      m_halt  = 1'b1;
   endtask

   task automatic model_step();
      logic [7:0]    opc, opd;
      logic [DW-1:0] a, b, r;
      int unsigned   npc;
      e_outwr   = 1'b0;
      e_memwr   = 1'b0;
      pc_before = m_pc;
      if (m_halt) return;
      opc = prog[m_pc][15:8];
      opd = prog[m_pc][7:0];
      npc = (m_pc + 1) % PCMOD;
      case (opc)
         8'h00: ;
         8'h01: begin
            if (stk.size() == DEPTH) begin mfault(2'b01); return; end
            stk.push_back(DW'(opd));
         end
         8'h02: begin
            if (stk.size() < 1) begin mfault(2'b10); return; end
            m_out = stk[$]; e_outwr = 1'b1;
         end
         8'h03, 8'h04, 8'h05, 8'h08, 8'h09: begin
            if (opc == 8'h05 && !MUL_EN) begin mfault(2'b11); return; end
            if (stk.size() < 2) begin mfault(2'b10); return; end
            b = stk.pop_back();
            a = stk.pop_back();
            case (opc)
               8'h03:   r = a + b;
               8'h04:   r = a - b;
               8'h05:   r = a * b;
               8'h08:   r = a & b;
               default: r = a | b;
            endcase
            stk.push_back(r);
         end
         8'h06: begin
            if (stk.size() < 1) begin mfault(2'b10); return; end
            m_wr = stk.pop_back(); e_memwr = 1'b1; e_addr = opd;
            m_dmem[opd] = m_wr;
         end
         8'h07: begin
            if (stk.size() == DEPTH) begin mfault(2'b01); return; end
            stk.push_back(m_dmem[opd]);
         end
         8'h0A: begin
            if (stk.size() < 1) begin mfault(2'b10); return; end
            if (stk.size() == DEPTH) begin mfault(2'b01); return; end
            stk.push_back(stk[$]);
         end
         8'h0B: begin
            if (stk.size() < 1) begin mfault(2'b10); return; end
            void'(stk.pop_back());
         end
         8'h0C: npc = opd;
         8'h0D: begin
            if (stk.size() < 1) begin mfault(2'b10); return; end
            if (stk.pop_back() == '0) npc = opd;
         end
         8'hFF: begin m_halt = 1'b1; return; end
         default: begin mfault(2'b11); return; end
      endcase
      m_pc = npc;
   endtask

   task automatic run_insn();
      model_step();
      @(posedge clk); #1;
      chk("halted",   halted,   m_halt);
      chk("fault",    fault,    m_fault);
      chk("sp",       sp,       stk.size());
      chk("pc_mem",   pc,       pc_before);
      chk("out_wr",   out_wr,   e_outwr);
      chk("out_data", out_data, m_out);
      chk("mem_wr",   mem_wr,   e_memwr);
      chk("wr_data",  wr_data,  m_wr);
      if (e_memwr) chk("mem_addr", mem_addr, e_addr);
      if (mem_wr) dmem[mem_addr] = wr_data;
      @(posedge clk); #1;
      chk("pc", pc, m_pc);
      chk("strobe_idle", {out_wr, mem_wr}, 2'b00);
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 1024; i++) prog[i] = 16'h0000;
   endtask

   task automatic start_prog();
      rst_n = 1'b0;
      for (int i = 0; i < 256; i++) begin
         dmem[i]   = DW'($urandom);
         m_dmem[i] = dmem[i];
      end
      stk.delete();
      m_pc = 0; m_out = '0; m_wr = '0; m_fault = 2'b00; m_halt = 1'b0;
      @(posedge clk); #1;
      chk("rst_pc", pc, 0);
      chk("rst_sp", sp, 0);
      chk("rst_out", {out_data, wr_data}, 0);
      chk("rst_strobes", {out_wr, mem_wr, halted, fault}, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [15:0] rand_insn();
      logic [7:0] opd;
      opd = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 19))
         0, 1, 2, 3, 4: return {8'h01, ($urandom_range(0, 3) == 0) ? 8'h00 : opd};
         5:  return {8'h02, opd};
         6:  return {8'h03, opd};
         7:  return {8'h04, opd};
         8:  return {8'h05, opd};
         9:  return {8'h06, 8'($urandom_range(0, 15))};
         10: return {8'h07, 8'($urandom_range(0, 15))};
         11: return {8'h08, opd};
         12: return {8'h09, opd};
         13: return {8'h0A, opd};
         14: return {8'h0B, opd};
         15: return {8'h0C, 8'($urandom_range(0, 63))};
         16: return {8'h0D, 8'($urandom_range(0, 63))};
         18: return ($urandom_range(0, 3) == 0) ? 16'hFF00 : 16'h0000;
         19: return ($urandom_range(0, 3) == 0) ? {8'($urandom_range(14, 254)), opd} : 16'h0000;
         default: return {8'h00, opd};
      endcase
   endfunction

   initial begin
      rst_n = 1'b0;

      // Add then output
      clear_prog();
      prog[0] = 16'h0103; prog[1] = 16'h0105; prog[2] = 16'h0300; prog[3] = 16'h0200;
      start_prog();
      repeat (4) run_insn();
      chk("add_out_val", out_data, 8'h08);
      chk("add_out_pc", pc, 4);

      // Wrap-around add then store
      clear_prog();
      prog[0] = 16'h01FF; prog[1] = 16'h0102; prog[2] = 16'h0300; prog[3] = 16'h0610;
      start_prog();
      repeat (4) run_insn();
      chk("st_mem", dmem[8'h10], 8'h01);
      chk("st_sp", sp, 0);

      // Overflow on fifth push with a 4-entry stack
      clear_prog();
      for (int i = 0; i < 6; i++) prog[i] = {8'h01, 8'(i + 1)};
      start_prog();
      repeat (8) run_insn();
      chk("ovf_state", {halted, fault}, 3'b101);
      chk("ovf_sp", sp, 4);
      chk("ovf_pc", pc, 4);

      // Underflow on first instruction
      clear_prog();
      prog[0] = 16'h0300;
      start_prog();
      repeat (2) run_insn();
      chk("unf_fault", fault, 2'b10);
      chk("unf_pc", pc, 0);

      // Illegal opcode
      clear_prog();
      prog[0] = 16'h0107; prog[1] = 16'h4200;
      start_prog();
      repeat (3) run_insn();
      chk("ill_fault", fault, 2'b11);
      chk("ill_pc", pc, 1);

      // JZ taken and not taken
      clear_prog();
      prog[0] = 16'h0100; prog[1] = 16'h0D20;
      start_prog();
      repeat (2) run_insn();
      chk("jz_taken_pc", pc, 10'h20);
      chk("jz_taken_sp", sp, 0);
      clear_prog();
      prog[0] = 16'h0101; prog[1] = 16'h0D20;
      start_prog();
      repeat (2) run_insn();
      chk("jz_not_pc", pc, 2);

      // Multiply, legal only with the optional multiplier
      clear_prog();
      prog[0] = 16'h0102; prog[1] = 16'h0103; prog[2] = 16'h0500; prog[3] = 16'h0200;
      start_prog();
      repeat (5) run_insn();
      chk("mul_fault", fault, MUL_EN ? 2'b00 : 2'b11);
      chk("mul_out", out_data, MUL_EN ? 8'h06 : 8'h00);

      // Reset during the store's MEM cycle must kill the write strobe
      clear_prog();
      prog[0] = 16'h0105; prog[1] = 16'h0620;
      start_prog();
      run_insn();
      @(posedge clk); #1;
      chk("mid_mem_wr_before", mem_wr, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_mem_wr_after", mem_wr, 1'b0);
      chk("mid_pc_sp", {pc, sp}, 0);
      @(posedge clk); #1;
      chk("mid_held", {mem_wr, out_wr, halted}, 3'b000);

      // Random programs
      for (int t = 0; t < 30; t++) begin
         for (int i = 0; i < 1024; i++) prog[i] = rand_insn();
         prog[0] = {8'h01, 8'($urandom)};
         prog[1] = {8'h01, 8'($urandom)};
         start_prog();
         repeat (40) run_insn();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/stack_cpu.md
STACK_CPU -- requirements
Module: stack_cpu

Interface
REQ-001 Parameter DW, default 8: data and stack-entry width in bits, 8..32.
REQ-002 Parameter DEPTH, default 16: operand-stack entries, power of two, 4..64.
REQ-003 Parameter PCW, default 10: program-counter width.
REQ-004 The module SHALL have one clock and an asynchronous active-low reset.
REQ-005 Port list:
  clk  in  1  clock; all state changes on rising edge
  rst_n  in  1  asynchronous active-low reset
  insn  in  16  instruction at pc: [15:8] opcode, [7:0] operand
  pc  out  PCW  instruction address
  mem_addr  out  8  data address = insn[7:0], combinational
  rd_data  in  DW  asynchronous-read data memory output
  mem_wr  out  1  data-memory write strobe
  wr_data  out  DW  store data
  out_data  out  DW  output-port value
  out_wr  out  1  one-cycle out_data update strobe
  sp  out  $clog2(DEPTH)+1  stack occupancy
  halted  out  1  core stopped
  fault  out  2  00 none, 01 overflow, 10 underflow, 11 illegal opcode

Function
REQ-006 States: EXEC, MEM, HALT. EXEC->MEM always; MEM->EXEC always; any fault or HALT opcode in EXEC->HALT; HALT held until reset.
REQ-007 Every instruction takes exactly 2 cycles. Opcode acts at the EXEC edge; pc updates at the MEM edge.
REQ-008 pc at MEM edge: jump target if taken, else pc+1, wrapping mod 2^PCW.
REQ-009 Opcodes: 00 NOP; 01 PUSH zero-extended operand; 02 OUT (out_data<=top, out_wr=1 during MEM, no pop); 03 ADD; 04 SUB (next minus top); 05 MUL; 06 ST (wr_data<=top, mem_wr=1 during MEM, pop); 07 LD (push rd_data); 08 AND; 09 OR; 0A DUP; 0B DROP; 0C JMP (target zero-extended operand); 0D JZ (pop; jump if popped value ==0); FF HALT; all others illegal.
REQ-010 Binary ops pop two and push one; result truncated to DW bits, wrap-around, no carry flag.
REQ-011 Stack is a true DEPTH-entry LIFO with pointer; no shifting of entries beyond top.
REQ-012 Overflow: push with sp==DEPTH -> fault=01, stack and sp unchanged, HALT.
REQ-013 Underflow: op needing N operands with sp<N -> fault=10, stack unchanged, HALT.
REQ-014 Illegal opcode -> fault=11, HALT; no stack, pc or memory side effect.
REQ-015 Faulting or HALT instruction does not advance pc; pc shows its address.
REQ-016 In HALT: mem_wr=0, out_wr=0, pc, sp, out_data, fault frozen; halted=1.
REQ-017 mem_wr and out_wr never asserted outside MEM, never both in one cycle.

Reset
REQ-018 On rst_n low, asynchronously: state=EXEC, pc=0, sp=0, out_data=0, out_wr=0, mem_wr=0, wr_data=0, halted=0, fault=00.
REQ-019 Stack-entry contents are not reset; reads below sp never occur.
REQ-020 Reset mid-instruction aborts it; no write strobe completes.

Configuration
REQ-021 Macro STACK_CPU_MUL_EN defined: opcode 05 multiplies, DW x DW keeping low DW bits.
REQ-022 Macro absent: no multiplier synthesised; opcode 05 is illegal (fault=11).

Structure
REQ-023 Package cpu_pkg holds opcode enum, state enum, fault codes.
REQ-024 Sub-module stack_cpu_alu: combinational ADD/SUB/MUL/AND/OR, DW-parameterised, MUL gated by STACK_CPU_MUL_EN.

Verification
REQ-025 DW=8: PUSH 3, PUSH 5, ADD, OUT -> out_data=0x08, out_wr one cycle at cycle 7, pc=4 after cycle 8.
REQ-026 PUSH 0xFF, PUSH 2, ADD, ST 0x10 -> mem_wr=1, mem_addr=0x10, wr_data=0x01, sp=0.
REQ-027 DEPTH=4: five PUSH -> fault=01, halted=1, sp=4, pc=4 and frozen.
REQ-028 ADD on empty stack -> fault=10 at pc=0; opcode 0x42 -> fault=11.
REQ-029 PUSH 0, JZ 0x20 -> pc=0x20, sp=0; PUSH 1, JZ 0x20 -> pc=2.
REQ-030 Without STACK_CPU_MUL_EN: PUSH 2, PUSH 3, MUL -> fault=11; with it, out of OUT is 0x06.
